// File: rtl/udp_tx_socket_arbiter_if.sv
// Bundle of the per-requester transmit socket signals and the shared UDP layer-4 side.
// The arbiter connects through the slave modport; the application/UDP side uses master.
interface udp_tx_socket_arbiter_if #(
    parameter int NUM_PORTS = 4
);
    logic [NUM_PORTS-1:0]    req_pending;
    logic [NUM_PORTS-1:0]    grant;
    logic [NUM_PORTS-1:0]    req_start;
    logic [16*NUM_PORTS-1:0] req_src_port;
    logic [16*NUM_PORTS-1:0] req_dst_port;
    logic [32*NUM_PORTS-1:0] req_dst_ip;
    logic [16*NUM_PORTS-1:0] req_payload_len;
    logic [NUM_PORTS-1:0]    req_data_valid;
    logic [3*NUM_PORTS-1:0]  req_bytes_valid;
    logic [32*NUM_PORTS-1:0] req_data;
    logic [NUM_PORTS-1:0]    req_commit;
    logic [NUM_PORTS-1:0]    req_drop;
    logic                    out_ready;
    logic                    out_start;
    logic                    out_data_valid;
    logic                    out_commit;
    logic                    out_drop;
    logic [15:0]             out_src_port;
    logic [15:0]             out_dst_port;
    logic [31:0]             out_dst_ip;
    logic [15:0]             out_payload_len;
    logic [2:0]              out_bytes_valid;
    logic [31:0]             out_data;
    logic [15:0]             timeout_count;
    logic [2:0]              timeout_port;

    modport master (
        output req_pending, req_start, req_src_port, req_dst_port, req_dst_ip,
               req_payload_len, req_data_valid, req_bytes_valid, req_data,
               req_commit, req_drop, out_ready,
        input  grant, out_start, out_data_valid, out_commit, out_drop,
               out_src_port, out_dst_port, out_dst_ip, out_payload_len,
               out_bytes_valid, out_data, timeout_count, timeout_port
    );

    modport slave (
        input  req_pending, req_start, req_src_port, req_dst_port, req_dst_ip,
               req_payload_len, req_data_valid, req_bytes_valid, req_data,
               req_commit, req_drop, out_ready,
        output grant, out_start, out_data_valid, out_commit, out_drop,
               out_src_port, out_dst_port, out_dst_ip, out_payload_len,
               out_bytes_valid, out_data, timeout_count, timeout_port
    );
endinterface

// File: rtl/udp_tx_socket_arbiter.sv
// Frame-granular round-robin arbiter sharing one UDP transmit socket between requesters,
// with a per-grant idle watchdog that reclaims the socket and aborts a started frame.
module udp_tx_socket_arbiter #(
    parameter int NUM_PORTS      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    udp_tx_socket_arbiter_if.slave  bus
);
    localparam int              WD_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, RELEASE} state_t;

    state_t               r_state;
    logic [NUM_PORTS-1:0] r_grant;
    logic [2:0]           r_sel;
    logic [2:0]           r_rr_last;
    logic [WD_W-1:0]      r_wdog;
    logic                 r_started;
    logic                 r_tmo_drop;
    logic [15:0]          r_timeout_count;
    logic [2:0]           r_timeout_port;

    // Per-port views padded to 8 entries so a 3-bit index always fits.
    logic [7:0]  w_pend, w_start, w_dv, w_commit, w_drop;
    logic [15:0] w_src [8];
    logic [15:0] w_dst [8];
    logic [31:0] w_ip  [8];
    logic [15:0] w_len [8];
    logic [2:0]  w_bv  [8];
    logic [31:0] w_dat [8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_port
            if (gi < NUM_PORTS) begin : g_used
                assign w_pend[gi]   = bus.req_pending[gi];
                assign w_start[gi]  = bus.req_start[gi];
                assign w_dv[gi]     = bus.req_data_valid[gi];
                assign w_commit[gi] = bus.req_commit[gi];
                assign w_drop[gi]   = bus.req_drop[gi];
                assign w_src[gi]    = bus.req_src_port[16*gi +: 16];
                assign w_dst[gi]    = bus.req_dst_port[16*gi +: 16];
                assign w_ip[gi]     = bus.req_dst_ip[32*gi +: 32];
                assign w_len[gi]    = bus.req_payload_len[16*gi +: 16];
                assign w_bv[gi]     = bus.req_bytes_valid[3*gi +: 3];
                assign w_dat[gi]    = bus.req_data[32*gi +: 32];
            end else begin : g_unused
                assign w_pend[gi]   = 1'b0;
                assign w_start[gi]  = 1'b0;
                assign w_dv[gi]     = 1'b0;
                assign w_commit[gi] = 1'b0;
                assign w_drop[gi]   = 1'b0;
                assign w_src[gi]    = '0;
                assign w_dst[gi]    = '0;
                assign w_ip[gi]     = '0;
                assign w_len[gi]    = '0;
                assign w_bv[gi]     = '0;
                assign w_dat[gi]    = '0;
            end
        end
    endgenerate

    // Round-robin pick: first pending port searching upward from rr_last+1, wrapping.
    logic [2:0] w_sel;
    logic       w_found;
    always_comb begin
        w_sel   = r_rr_last;
        w_found = 1'b0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            if (!w_found && w_pend[(int'(r_rr_last) + k) % NUM_PORTS]) begin
                w_found = 1'b1;
                w_sel   = 3'((int'(r_rr_last) + k) % NUM_PORTS);
            end
        end
    end

    // Granted-port strobes; zero outside ACTIVE so nothing leaks during RELEASE.
    logic w_active, w_g_start, w_g_dv, w_g_commit, w_g_drop, w_g_any;
    always_comb begin
        w_active   = (r_state == ACTIVE);
        w_g_start  = w_active & w_start[r_sel];
        w_g_dv     = w_active & w_dv[r_sel];
        w_g_commit = w_active & w_commit[r_sel];
        w_g_drop   = w_active & w_drop[r_sel];
        w_g_any    = w_g_start | w_g_dv | w_g_commit | w_g_drop;
    end

    always_comb begin
        bus.out_start       = w_g_start;
        bus.out_data_valid  = w_g_dv;
        bus.out_commit      = w_g_commit;
        bus.out_drop        = w_g_drop | r_tmo_drop;
        bus.out_src_port    = '0;
        bus.out_dst_port    = '0;
        bus.out_dst_ip      = '0;
        bus.out_payload_len = '0;
        bus.out_bytes_valid = '0;
        bus.out_data        = '0;
        if (w_active) begin
            bus.out_src_port    = w_src[r_sel];
            bus.out_dst_port    = w_dst[r_sel];
            bus.out_dst_ip      = w_ip[r_sel];
            bus.out_payload_len = w_len[r_sel];
            bus.out_bytes_valid = w_bv[r_sel];
            bus.out_data        = w_dat[r_sel];
        end
    end

    assign bus.grant         = r_grant;
    assign bus.timeout_count = r_timeout_count;
    assign bus.timeout_port  = r_timeout_port;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_grant         <= '0;
            r_sel           <= '0;
            r_rr_last       <= 3'(NUM_PORTS - 1);
            r_wdog          <= '0;
            r_started       <= 1'b0;
            r_tmo_drop      <= 1'b0;
            r_timeout_count <= '0;
            r_timeout_port  <= '0;
        end else begin
            r_tmo_drop <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.out_ready && w_found) begin
                        r_grant   <= NUM_PORTS'(1) << w_sel;
                        r_sel     <= w_sel;
                        r_rr_last <= w_sel;
                        r_wdog    <= '0;
                        r_started <= 1'b0;
                        r_state   <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (w_g_start)
                        r_started <= 1'b1;
                    if (w_g_commit || w_g_drop) begin
                        r_grant <= '0;
                        r_state <= RELEASE;
                    end else if (w_g_any) begin
                        r_wdog <= '0;
                    end else if (r_wdog == WD_LAST) begin
                        // Forced release: abort downstream only if a frame was opened.
                        r_grant        <= '0;
                        r_state        <= RELEASE;
                        r_tmo_drop     <= r_started;
                        r_timeout_port <= r_sel;
                        if (r_timeout_count != 16'hFFFF)
                            r_timeout_count <= r_timeout_count + 16'd1;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                RELEASE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_udp_tx_socket_arbiter.sv
// Directed bench for the UDP transmit socket arbiter: arbitration order, release gap,
// watchdog aborts, out_ready blocking and mid-frame reset.
module tb_udp_tx_socket_arbiter;
    localparam int NP  = 4;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    udp_tx_socket_arbiter_if #(.NUM_PORTS(NP)) bus_if ();

    udp_tx_socket_arbiter #(.NUM_PORTS(NP), .TIMEOUT_CYCLES(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus_if.req_pending    = '0;
        bus_if.req_start      = '0;
        bus_if.req_data_valid = '0;
        bus_if.req_commit     = '0;
        bus_if.req_drop       = '0;
        bus_if.out_ready      = 1'b1;
        for (int p = 0; p < NP; p++) begin
            bus_if.req_src_port[16*p +: 16]    = 16'h1000 + 16'(p);
            bus_if.req_dst_port[16*p +: 16]    = 16'h2000 + 16'(p);
            bus_if.req_dst_ip[32*p +: 32]      = 32'h0A000000 + 32'(p);
            bus_if.req_payload_len[16*p +: 16] = 16'd12;
            bus_if.req_bytes_valid[3*p +: 3]   = 3'd4;
            bus_if.req_data[32*p +: 32]        = 32'hEE000000 + 32'(p);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        adv();
        adv();
        rst = 1'b0;
    endtask

    // Advance until a grant appears; returns granted index and cycles waited.
    task automatic wait_grant(output int idx, output int cycles);
        idx    = -1;
        cycles = 0;
        for (int c = 0; c < 40; c++) begin
            adv();
            cycles++;
            if (bus_if.grant != '0) break;
        end
        for (int p = 0; p < NP; p++)
            if (bus_if.grant == NP'(1 << p)) idx = p;
        if (idx < 0) chk("grant_wait", 32'(bus_if.grant), 32'hFFFF_FFFF);
        $display("grant port=%0d after %0d cycles", idx, cycles);
    endtask

    // Start + nwords data words on port p; optionally commit. Ends one cycle after the last strobe.
    task automatic send_frame(input int p, input int nwords, input bit do_commit);
        bus_if.req_start[p] = 1'b1;
        #1;
        chk("start", 32'(bus_if.out_start), 32'd1);
        chk("src_port", 32'(bus_if.out_src_port), 32'h1000 + 32'(p));
        chk("dst_ip", bus_if.out_dst_ip, 32'h0A000000 + 32'(p));
        adv();
        bus_if.req_start[p] = 1'b0;
        for (int w = 0; w < nwords; w++) begin
            bus_if.req_data_valid[p]     = 1'b1;
            bus_if.req_data[32*p +: 32]  = {8'hD0 + 8'(p), 24'(w)};
            #1;
            chk("data", bus_if.out_data, {8'hD0 + 8'(p), 24'(w)});
            chk("data_valid", 32'(bus_if.out_data_valid), 32'd1);
            adv();
            bus_if.req_data_valid[p] = 1'b0;
        end
        if (do_commit) begin
            bus_if.req_commit[p] = 1'b1;
            #1;
            chk("commit", 32'(bus_if.out_commit), 32'd1);
            adv();
            bus_if.req_commit[p] = 1'b0;
            #1;
            chk("grant_after_commit", 32'(bus_if.grant), 32'd0);
        end
        $display("frame port=%0d words=%0d commit=%0d", p, nwords, do_commit);
    endtask

    int idx, cyc, any_drop, any_grant;
    int order [5] = '{0, 1, 2, 3, 0};

    initial begin
        clear_inputs();
        do_reset();
        chk("rst_grant", 32'(bus_if.grant), 32'd0);
        chk("rst_tcount", 32'(bus_if.timeout_count), 32'd0);
        chk("rst_tport", 32'(bus_if.timeout_port), 32'd0);
        chk("rst_drop", 32'(bus_if.out_drop), 32'd0);
        chk("rst_data", bus_if.out_data, 32'd0);

        // Ports 0 and 2 pending: port 0 first, port 2 three cycles after commit.
        bus_if.req_pending = 4'b0101;
        wait_grant(idx, cyc);
        chk("t1_grant0", 32'(bus_if.grant), 32'b0001);
        chk("t1_latency", 32'(cyc), 32'd1);
        bus_if.req_pending = 4'b0100;
        send_frame(0, 1, 1'b1);
        adv();
        chk("t1_gap", 32'(bus_if.grant), 32'd0);
        adv();
        chk("t1_grant2", 32'(bus_if.grant), 32'b0100);

        // All ports pending continuously: strict rotation, 3-cycle gap each frame.
        do_reset();
        bus_if.req_pending = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            wait_grant(idx, cyc);
            chk("t2_order", 32'(idx), 32'(order[f]));
            if (f > 0) chk("t2_gap", 32'(cyc), 32'd2);
            send_frame(order[f], 3, 1'b1);
        end

        // Port 1 stalls after start + 2 words: drop after 16 idle cycles.
        do_reset();
        bus_if.req_pending = 4'b0010;
        wait_grant(idx, cyc);
        chk("t3_grant", 32'(idx), 32'd1);
        bus_if.req_pending = '0;
        send_frame(1, 2, 1'b0);
        any_drop  = 0;
        any_grant = 1;
        for (int k = 1; k <= TMO; k++) begin
            if (bus_if.out_drop) any_drop = 1;
            if (bus_if.grant != 4'b0010) any_grant = 0;
            adv();
        end
        chk("t3_no_early_drop", 32'(any_drop), 32'd0);
        chk("t3_held_grant", 32'(any_grant), 32'd1);
        chk("t3_drop", 32'(bus_if.out_drop), 32'd1);
        chk("t3_grant_rel", 32'(bus_if.grant), 32'd0);
        chk("t3_tcount", 32'(bus_if.timeout_count), 32'd1);
        chk("t3_tport", 32'(bus_if.timeout_port), 32'd1);
        adv();
        chk("t3_drop_once", 32'(bus_if.out_drop), 32'd0);
        $display("timeout port=%0d count=%0d", bus_if.timeout_port, bus_if.timeout_count);

        // Port 3 granted, never starts: silent timeout, count accumulates.
        bus_if.req_pending = 4'b1000;
        wait_grant(idx, cyc);
        chk("t4_grant", 32'(idx), 32'd3);
        bus_if.req_pending = '0;
        any_drop = 0;
        for (int k = 0; k < TMO; k++) begin
            if (bus_if.out_drop) any_drop = 1;
            adv();
        end
        if (bus_if.out_drop) any_drop = 1;
        chk("t4_no_drop", 32'(any_drop), 32'd0);
        chk("t4_grant_rel", 32'(bus_if.grant), 32'd0);
        chk("t4_tcount", 32'(bus_if.timeout_count), 32'd2);
        chk("t4_tport", 32'(bus_if.timeout_port), 32'd3);
        $display("timeout port=%0d count=%0d", bus_if.timeout_port, bus_if.timeout_count);

        // out_ready low for 10 cycles blocks grants.
        do_reset();
        bus_if.req_pending = 4'b0011;
        bus_if.out_ready   = 1'b0;
        any_grant = 0;
        for (int c = 0; c < 10; c++) begin
            adv();
            if (bus_if.grant != '0) any_grant = 1;
        end
        chk("t5_blocked", 32'(any_grant), 32'd0);
        bus_if.out_ready = 1'b1;
        adv();
        chk("t5_grant", 32'(bus_if.grant), 32'b0001);
        $display("ready release grant=%b", bus_if.grant);

        // Reset mid-frame on port 2: silent discard, then port 0 wins.
        do_reset();
        bus_if.req_pending = 4'b0100;
        wait_grant(idx, cyc);
        chk("t6_grant", 32'(idx), 32'd2);
        send_frame(2, 1, 1'b0);
        bus_if.req_data_valid[2] = 1'b1;
        rst = 1'b1;
        adv();
        rst = 1'b0;
        bus_if.req_pending = 4'b0101;
        chk("t6_grant_rst", 32'(bus_if.grant), 32'd0);
        chk("t6_drop_rst", 32'(bus_if.out_drop), 32'd0);
        chk("t6_dv_rst", 32'(bus_if.out_data_valid), 32'd0);
        chk("t6_data_rst", bus_if.out_data, 32'd0);
        bus_if.req_data_valid[2] = 1'b0;
        wait_grant(idx, cyc);
        chk("t6_port0_first", 32'(idx), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=hang exp=finish");
        $fatal(1);
    end
endmodule

// File: doc/udp_tx_socket_arbiter.md
Name: udp_tx_socket_arbiter

Overview:
- Shares the single UDP transmit socket interface of the IPv4 stack between NUM_PORTS application requesters.
- Frame-granular round-robin: a grant holds for one whole frame, from start to commit or drop.
- Sits between application cores and the UDP layer-4 transmit input, in the clk_ipstack domain.
- A per-grant watchdog reclaims the socket from a stalled requester and aborts its partial frame.

Parameters:
NUM_PORTS, 4, number of requesters (2..8)
TIMEOUT_CYCLES, 1024, idle cycles allowed while granted before forced release (≥2)

Ports:
clk  in  1  clk_ipstack domain clock
rst  in  1  synchronous active-high reset
req_pending  in  NUM_PORTS  requester i has a complete frame ready to send
grant  out  NUM_PORTS  one-hot grant, registered
req_start  in  NUM_PORTS  frame start strobe, metadata valid
req_src_port  in  16*NUM_PORTS  UDP source port per requester
req_dst_port  in  16*NUM_PORTS  UDP destination port
req_dst_ip  in  32*NUM_PORTS  IPv4 destination address
req_payload_len  in  16*NUM_PORTS  payload byte count
req_data_valid  in  NUM_PORTS  data word valid
req_bytes_valid  in  3*NUM_PORTS  valid bytes in word, 1..4, MSB-first
req_data  in  32*NUM_PORTS  payload word
req_commit  in  NUM_PORTS  end of frame, send
req_drop  in  NUM_PORTS  abort frame
out_ready  in  1  UDP layer can accept a new frame
out_start, out_data_valid, out_commit, out_drop  out  1 each  muxed strobes
out_src_port, out_dst_port  out  16 each  muxed metadata
out_dst_ip  out  32  muxed metadata
out_payload_len  out  16  muxed metadata
out_bytes_valid  out  3  muxed byte count
out_data  out  32  muxed payload
timeout_count  out  16  saturating count of watchdog releases
timeout_port  out  3  index of last timed-out requester

Behaviour:
- Reset: grant=0; all out_* strobes 0 and buses 0; timeout_count=0; timeout_port=0; state=IDLE; rr_last=NUM_PORTS-1, so port 0 has first priority. Reset mid-frame discards the frame silently; no out_drop is emitted.
- States: IDLE, ACTIVE, RELEASE.
- IDLE:
  - If out_ready=1 and req_pending≠0, choose the first set bit searching upward from rr_last+1, with wrap-around.
  - Cycle N+1: grant=onehot(sel), rr_last=sel, watchdog=0, started=0, state→ACTIVE.
  - Latency pending→grant: 1 cycle.
- ACTIVE:
  - Outputs are a combinational mux of the granted port's inputs; zero-latency pass-through.
  - Strobes and buses from non-granted ports are ignored; outputs are 0 when no grant.
  - out_start sets started=1.
  - req_pending and out_ready are not re-examined mid-frame.
- End of frame: granted commit or drop at cycle N passes through at N. At N+1, grant=0 and state=RELEASE.
- RELEASE: 1 cycle, outputs 0, then IDLE. Earliest next grant is N+3. This gap guarantees no back-to-back frames.
- Watchdog:
  - In ACTIVE it increments on each cycle with no start, data_valid, commit or drop from the granted port. Any such activity clears it.
  - On reaching TIMEOUT_CYCLES-1 with no activity, the next cycle does all of the following:
    - out_drop=1 (only if started=1);
    - grant=0 and state=RELEASE;
    - timeout_count += 1, saturating at 0xFFFF;
    - timeout_port = granted index.
  - While forcing the release, the granted port's inputs are masked, so its strobes in that cycle are ignored.
- Simultaneous commit and drop from the granted port: both are forwarded; the downstream treats drop as dominant. The frame ends either way.
- Repeated start while started=1: forwarded unchanged. The downstream UDP layer defines the semantics.
- A single requester asserting pending continuously is re-granted every 3 cycles per frame at minimum. Other pending ports always win the next arbitration after it.
- out_ready=0 in IDLE blocks new grants only.

Test Plan:
- Ports 0 and 2 pending after reset → grant=0001 first. Port 0 commits at cycle N → grant=0100 at N+3.
- All 4 ports pending continuously, each sending a 3-word frame → grant order 0,1,2,3,0. Each output frame carries the granted port's src_port and data unchanged.
- Port 1 granted and drives start plus 2 words, then goes silent, TIMEOUT_CYCLES=16 → out_drop pulses once 16 idle cycles after the last word; timeout_count=1, timeout_port=1, grant=0.
- Port 3 granted, never asserts start, times out → no out_drop; timeout_count increments.
- Ports 0 and 1 pending with out_ready=0 for 10 cycles → grant stays 0. out_ready rises at cycle 10 → grant=0001 at cycle 11.
- rst asserted mid-frame on port 2 → next cycle grant=0, all outputs 0, no out_drop. With port 2 pending again and port 0 also pending, port 0 is granted first.
